// File: rtl/parking_gate_scheduler.sv
// Parking barrier scheduler: arbitrates the entry and exit lanes onto a single
// barrier, sequences the barrier motor against its limit switches, counts
// vehicles that actually pass, and latches a fault when the motor stalls.
module parking_gate_scheduler #(
   parameter int unsigned CAPACITY      = 16,  // maximum vehicles inside (1..255)
   parameter int unsigned MOTOR_TIMEOUT = 32,  // cycles allowed to reach a limit switch
   parameter int unsigned PASS_TIMEOUT  = 64   // cycles allowed in HOLD without a vehicle
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       entry_req,
   input  logic       exit_req,
   input  logic       pass_sensor,
   input  logic       up_lim,
   input  logic       down_lim,
   output logic       motor_up,
   output logic       motor_down,
   output logic       entry_grant,
   output logic       exit_grant,
   output logic [7:0] occupancy,
   output logic       full,
   output logic       fault
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RAISE,
      ST_HOLD,
      ST_LOWER,
      ST_FAULT
   } state_t;

   typedef enum logic {
      LANE_ENTRY = 1'b0,
      LANE_EXIT  = 1'b1
   } lane_t;

   // One shared timer serves both motor supervision and the pass timeout.
   localparam int unsigned TIMER_MAX   = (MOTOR_TIMEOUT > PASS_TIMEOUT) ? MOTOR_TIMEOUT : PASS_TIMEOUT;
   localparam int          TW          = $clog2(TIMER_MAX + 1);
   localparam logic [TW-1:0] MOTOR_LIMIT = TW'(MOTOR_TIMEOUT);
   localparam logic [TW-1:0] PASS_LIMIT  = TW'(PASS_TIMEOUT - 1);
   localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
   localparam logic [7:0]    CAP         = 8'(CAPACITY);

   state_t        state;
   lane_t         lane;        // lane currently being served
   lane_t         last_lane;   // lane served most recently, for round-robin
   logic [TW-1:0] timer;
   logic          seen;        // a vehicle has been under the barrier this service
   logic          committed;   // this service has already been counted

   logic          entry_ok;
   logic          exit_ok;
   logic          req_any;
   lane_t         pick_lane;
   logic [7:0]    occ_up;
   logic [7:0]    occ_down;
   logic [7:0]    occ_commit;

   // Request eligibility, round-robin pick and saturating occupancy candidates.
   always_comb begin
      // NOTE: every always_comb output gets a value on every path (here via
      // straight-line assignments) so no latch can be inferred.
      entry_ok = entry_req && !full;
      exit_ok  = exit_req;
      req_any  = entry_ok || exit_ok;
      if (entry_ok && exit_ok) begin
         pick_lane = (last_lane == LANE_EXIT) ? LANE_ENTRY : LANE_EXIT;
      end else if (exit_ok) begin
         pick_lane = LANE_EXIT;
      end else begin
         pick_lane = LANE_ENTRY;
      end
      occ_up     = (occupancy >= CAP) ? CAP : occupancy + 8'd1;
      occ_down   = (occupancy == 8'd0) ? 8'd0 : occupancy - 8'd1;
      occ_commit = (lane == LANE_ENTRY) ? occ_up : occ_down;
   end

   // Barrier FSM with all outputs registered alongside the state.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         state       <= ST_IDLE;
         lane        <= LANE_ENTRY;
         last_lane   <= LANE_ENTRY;
         timer       <= '0;
         seen        <= 1'b0;
         committed   <= 1'b0;
         occupancy   <= 8'd0;
         full        <= 1'b0;
         fault       <= 1'b0;
         motor_up    <= 1'b0;
         motor_down  <= 1'b0;
         entry_grant <= 1'b0;
         exit_grant  <= 1'b0;
      end else begin
         // Grants are single-cycle pulses and motors run only when a state
         // body explicitly re-asserts them.
         entry_grant <= 1'b0;
         exit_grant  <= 1'b0;
         motor_up    <= 1'b0;
         motor_down  <= 1'b0;

         case (state)
            ST_IDLE: begin
               timer <= '0;
               if (req_any) begin
                  lane        <= pick_lane;
                  last_lane   <= pick_lane;
                  entry_grant <= (pick_lane == LANE_ENTRY);
                  exit_grant  <= (pick_lane == LANE_EXIT);
                  seen        <= 1'b0;
                  committed   <= 1'b0;
                  state       <= ST_RAISE;
               end
            end

            ST_RAISE: begin
               if (up_lim) begin
                  timer <= '0;
                  state <= ST_HOLD;
               end else if (timer == MOTOR_LIMIT) begin
                  fault <= 1'b1;
                  state <= ST_FAULT;
               end else begin
                  motor_up <= 1'b1;
                  timer    <= timer + TIMER_ONE;
               end
            end

            ST_HOLD: begin
               if (pass_sensor) begin
                  // Timer is frozen while a vehicle is under the barrier.
                  seen <= 1'b1;
               end else if (seen) begin
                  // Sensor has dropped after a vehicle: count it once only,
                  // even if a safety reversal brought us back here.
                  if (!committed) begin
                     occupancy <= occ_commit;
                     full      <= (occ_commit == CAP);
                     committed <= 1'b1;
                  end
                  timer <= '0;
                  state <= ST_LOWER;
               end else if (timer == PASS_LIMIT) begin
                  // Abandoned service: lower without touching occupancy.
                  timer <= '0;
                  state <= ST_LOWER;
               end else begin
                  timer <= timer + TIMER_ONE;
               end
            end

            ST_LOWER: begin
               if (pass_sensor) begin
                  // Safety reversal: never lower onto a vehicle.
                  timer <= '0;
                  state <= ST_RAISE;
               end else if (down_lim) begin
                  timer <= '0;
                  state <= ST_IDLE;
               end else if (timer == MOTOR_LIMIT) begin
                  fault <= 1'b1;
                  state <= ST_FAULT;
               end else begin
                  motor_down <= 1'b1;
                  timer      <= timer + TIMER_ONE;
               end
            end

            ST_FAULT: begin
               fault <= 1'b1;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/parking_gate_scheduler.md
PARKING_GATE_SCHEDULER -- requirements
Module: parking_gate_scheduler

Interface
REQ-001 The block SHALL have parameter CAPACITY, default 16, meaning maximum vehicles inside (1..255).
REQ-002 The block SHALL have parameter MOTOR_TIMEOUT, default 32, meaning maximum cycles to reach a limit switch.
REQ-003 The block SHALL have parameter PASS_TIMEOUT, default 64, meaning maximum cycles in HOLD without a vehicle.
REQ-004 The block SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port entry_req  input  1  level request from entry-lane controller (PIN accepted).
REQ-007 The block SHALL have port exit_req  input  1  level request from exit-lane ticket reader.
REQ-008 The block SHALL have port pass_sensor  input  1  vehicle present under barrier.
REQ-009 The block SHALL have port up_lim, down_lim  input  1 each  barrier limit switches.
REQ-010 The block SHALL have port motor_up, motor_down  output  1 each  barrier motor drives.
REQ-011 The block SHALL have port entry_grant, exit_grant  output  1 each  single-cycle grant pulses.
REQ-012 The block SHALL have port occupancy  output  8  vehicles inside; full  output  1  occupancy==CAPACITY; fault  output  1  latched motor fault.

Function
REQ-013 States SHALL be IDLE, RAISE, HOLD, LOWER, FAULT; all outputs registered.
REQ-014 IDLE: eligible requests are exit_req, and entry_req only when full=0; entry_req with full=1 SHALL remain pending and ungranted.
REQ-015 IDLE: single eligible request SHALL be granted; both eligible SHALL be resolved round-robin by last_lane bit (lane not served last wins; after reset, exit wins).
REQ-016 Grant: corresponding *_grant high exactly one cycle, lane latched, last_lane updated, next state RAISE; grant-to-motor_up latency 1 cycle.
REQ-017 RAISE: motor_up=1 until up_lim=1, then HOLD with motor_up=0 the next cycle; cycle timer reaching MOTOR_TIMEOUT without up_lim SHALL go FAULT.
REQ-018 HOLD: motors off; seen flag set on pass_sensor=1; pass_sensor falling while seen SHALL commit passage and go LOWER.
REQ-019 Commit: entry lane occupancy+1 saturating at CAPACITY; exit lane occupancy-1 saturating at 0; update visible the cycle after the falling edge.
REQ-020 HOLD: PASS_TIMEOUT cycles without pass_sensor=1 SHALL go LOWER with no occupancy change (abandoned); timer frozen while pass_sensor=1.
REQ-021 LOWER: motor_down=1 until down_lim=1, then IDLE; MOTOR_TIMEOUT without down_lim SHALL go FAULT.
REQ-022 LOWER: pass_sensor=1 SHALL immediately deassert motor_down and return to RAISE (safety reversal), keeping lane and seen flag, timer cleared.
REQ-023 motor_up and motor_down SHALL never be 1 simultaneously; both 0 in IDLE, HOLD, FAULT.
REQ-024 FAULT: fault=1, motors off, requests ignored, no grants; left only by rst.
REQ-025 Requests arriving outside IDLE SHALL be ignored until return to IDLE; no queuing beyond level inputs.
REQ-026 full SHALL be combinational-equivalent of registered occupancy==CAPACITY, updated same cycle as occupancy.

Reset
REQ-027 rst=1 SHALL force IDLE, occupancy=0, full=0, fault=0, last_lane=entry, timers and seen flag cleared, all motor and grant outputs 0, from the next clock edge, including mid-RAISE/LOWER.

Verification
REQ-028 Entry cycle: entry_req=1, up_lim after 5 cycles, pass_sensor pulse 3 cycles, down_lim after 4 -> entry_grant one pulse, motor_up 5 cycles, occupancy 0->1, return IDLE.
REQ-029 Contention: entry_req=exit_req=1 held after reset with occupancy=2 -> grants alternate exit, entry, exit; occupancy ends 1.
REQ-030 Full: occupancy=16, entry_req=1 -> no entry_grant, full=1; exit completes -> occupancy 15, full=0, entry granted next IDLE cycle.
REQ-031 Reversal: pass_sensor=1 during LOWER -> motor_down drops, motor_up=1 next cycle; re-pass counted once only.
REQ-032 Timeouts: up_lim never asserts -> fault=1 after 32 cycles, motors 0; HOLD with no vehicle 64 cycles -> LOWER, occupancy unchanged.
REQ-033 Reset mid-RAISE with occupancy=7 -> next cycle motor_up=0, occupancy=0, state IDLE.
